// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan scheduler:
// segment table, idle patterns and handshake FSM states.
package seg_pkg;

    localparam int DIGIT_W = 3;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEL_NONE  = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational {dp,hex} to active-low segment pattern.
module seg_decode
    import seg_pkg::*;
(
    input  logic [4:0] i_data,
    output logic [7:0] o_seg
);

    logic [7:0] w_raw;

    assign w_raw = SEG_TABLE[i_data[3:0]];
    assign o_seg = {w_raw[7] & ~i_data[4], w_raw[6:0]};

endmodule

// File: rtl/seg_scan_sched.sv
// Scan scheduler: steps one digit per slot, applies PWM blanking and hands
// {sel,seg} words to the HC595 shifter over a valid/ready handshake.
module seg_scan_sched
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [4:0]        wr_data,
    input  logic              commit,
    input  logic [2:0]        bright,
    input  logic              blank,
    output logic              sh_valid,
    input  logic              sh_ready,
    output logic [DIGITS-1:0] sh_sel,
    output logic [7:0]        sh_seg,
    output logic              commit_pend,
    output logic              frame_tick,
    output logic              overrun,
    output state_t            dbg_state
);

    localparam int CW    = $clog2(SCAN_DIV);
    localparam int SLOT8 = SCAN_DIV / 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    // Handshake: a word moves on any cycle with sh_valid && sh_ready; the
    // word is held stable until then unless a newer load event replaces it.

    logic [CW-1:0]      r_cnt;
    logic [DIGIT_W-1:0] r_digit;
    logic               r_first;
    logic [2:0]         r_bright;
    state_t             r_state;
    logic [DIGITS-1:0]  r_sel;
    logic [7:0]         r_seg;
    logic               r_overrun;
    logic               r_frame_tick;
    logic               r_commit_pend;
    logic [4:0]         r_shadow [DIGITS];
    logic [4:0]         r_active [DIGITS];

    logic               w_boundary;
    logic               w_slot_start;
    logic               w_blank_pt;
    logic               w_event;
    logic [CW:0]        w_blank_cnt;
    logic [7:0]         w_dec_seg;
    logic [DIGITS-1:0]  w_new_sel;
    logic [7:0]         w_new_seg;

    seg_decode u_decode (
        .i_data (r_active[r_digit]),
        .o_seg  (w_dec_seg)
    );

    // r_first marks the frame boundary that follows reset release.
    assign w_boundary   = r_first || (r_cnt == CNT_LAST && r_digit == DIGIT_W'(DIGITS - 1));
    assign w_slot_start = (r_cnt == '0);
    assign w_blank_cnt  = (CW + 1)'((int'(r_bright) + 1) * SLOT8);
    assign w_blank_pt   = (r_bright != 3'd7) && ({1'b0, r_cnt} == w_blank_cnt);
    assign w_event      = w_slot_start || w_blank_pt;

    always_comb begin
        w_new_sel = SEL_NONE;
        w_new_seg = SEG_BLANK;
        if (w_slot_start && !blank) begin
            w_new_sel = ~(DIGITS'(1) << r_digit);
            w_new_seg = w_dec_seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_digit  <= '0;
            r_first  <= 1'b1;
            r_bright <= 3'd7;
        end else begin
            r_first <= 1'b0;
            if (w_slot_start) begin
                r_bright <= bright;
            end
            if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_digit <= r_digit + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= SEL_NONE;
            r_seg     <= SEG_BLANK;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_event) begin
                r_sel   <= w_new_sel;
                r_seg   <= w_new_seg;
                r_state <= PEND;
                if (r_state == PEND && !sh_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_state == PEND && sh_ready) begin
                r_state <= IDLE;
            end
        end
    end

    // The copy reads the shadow as it was before this cycle's write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_commit_pend <= 1'b0;
            r_frame_tick  <= 1'b0;
        end else begin
            r_frame_tick <= w_boundary;
            if (wr_en) begin
                r_shadow[wr_addr] <= wr_data;
            end
            if (w_boundary && r_commit_pend) begin
                r_active      <= r_shadow;
                r_commit_pend <= commit;
            end else if (commit) begin
                r_commit_pend <= 1'b1;
            end
        end
    end

    assign sh_valid    = (r_state == PEND);
    assign sh_sel      = r_sel;
    assign sh_seg      = r_seg;
    assign overrun     = r_overrun;
    assign frame_tick  = r_frame_tick;
    assign commit_pend = r_commit_pend;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Randomised scoreboard bench for seg_scan_sched with a cycle-indexed
// reference model built from slot/frame arithmetic.
module tb_seg_scan_sched;
    import seg_pkg::*;

    localparam int SD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic       commit = 1'b0;
    logic [2:0] bright = 3'd7;
    logic       blank = 1'b0;
    logic       sh_ready = 1'b1;
    logic       sh_valid;
    logic [7:0] sh_sel;
    logic [7:0] sh_seg;
    logic       commit_pend;
    logic       frame_tick;
    logic       overrun;
    state_t     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];

    int         m_t = 0;
    logic       m_pend = 0;
    logic       m_cpend = 0;
    logic       m_tick = 0;
    logic       m_ovr = 0;
    logic [2:0] m_bright = 3'd7;
    logic [4:0] m_shadow [8];
    logic [4:0] m_active [8];

    seg_scan_sched #(.SCAN_DIV(SD), .DIGITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .bright      (bright),
        .blank       (blank),
        .sh_valid    (sh_valid),
        .sh_ready    (sh_ready),
        .sh_sel      (sh_sel),
        .sh_seg      (sh_seg),
        .commit_pend (commit_pend),
        .frame_tick  (frame_tick),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_decode(input logic [4:0] d);
        logic [7:0] s;
        case (d[3:0])
            4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
            4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
            4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
            4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
        endcase
        if (d[4]) s[7] = 1'b0;
        return s;
    endfunction

    // reference model: cycle t since reset release, slot/digit by division
    always @(negedge clk) begin
        if (rst) begin
            m_t = 0; m_pend = 0; m_cpend = 0; m_tick = 0; m_ovr = 0;
            for (int i = 0; i < 8; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
            exp_q.delete();
        end else begin
            int cnt, dig;
            logic ev, bnd, ovr_next;
            logic [15:0] word;
            check("sh_valid", 16'(sh_valid), 16'(m_pend));
            check("commit_pend", 16'(commit_pend), 16'(m_cpend));
            check("frame_tick", 16'(frame_tick), 16'(m_tick));
            check("overrun", 16'(overrun), 16'(m_ovr));
            cnt = m_t % SD;
            dig = (m_t / SD) % 8;
            bnd = (m_t == 0) || (cnt == SD - 1 && dig == 7);
            ev = 1'b0;
            word = 16'hFFFF;
            if (cnt == 0) begin
                m_bright = bright;
                ev = 1'b1;
                if (!blank) word = {~(8'h01 << dig), ref_decode(m_active[dig])};
            end else if (m_bright != 3'd7 && cnt == (int'(m_bright) + 1) * (SD / 8)) begin
                ev = 1'b1;
            end
            ovr_next = 1'b0;
            if (ev) begin
                if (m_pend && !sh_ready) begin
                    ovr_next = 1'b1;
                    if (exp_q.size() > 0) void'(exp_q.pop_back());
                end
                exp_q.push_back(word);
                m_pend = 1'b1;
            end else if (m_pend && sh_ready) begin
                m_pend = 1'b0;
            end
            m_ovr = ovr_next;
            m_tick = bnd;
            if (bnd && m_cpend) begin
                for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
                m_cpend = commit;
            end else if (commit) begin
                m_cpend = 1'b1;
            end
            if (wr_en) m_shadow[wr_addr] = wr_data;
            m_t++;
        end
    end

    // monitor: every transfer pops the oldest expected word
    always @(negedge clk) begin
        if (!rst && sh_valid && sh_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", {sh_sel, sh_seg}, 16'h0000);
            end else begin
                logic [15:0] w;
                w = exp_q.pop_front();
                check("word", {sh_sel, sh_seg}, w);
            end
        end
    end

    // driver tasks
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_phase(input int period, input int val);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (m_t % period == val) return;
        end
        check("wait_phase_timeout", 16'd1, 16'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 16'(sh_valid), 16'd0);
        check({tag, "_sel"}, 16'(sh_sel), 16'hFF);
        check({tag, "_seg"}, 16'(sh_seg), 16'hFF);
        check({tag, "_cpend"}, 16'(commit_pend), 16'd0);
        check({tag, "_tick"}, 16'(frame_tick), 16'd0);
        check({tag, "_ovr"}, 16'(overrun), 16'd0);
    endtask

    initial begin
        // reset and release
        step(3);
        check_reset_outputs("reset");
        rst = 1'b0;

        // plain scan at full brightness
        step(2);
        check("first_sel", 16'(sh_sel), 16'hFE);
        check("first_seg", 16'(sh_seg), 16'hC0);
        step(280);

        // shadow write plus mid-frame commit
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'h18;
        step(1);
        wr_en = 1'b0; commit = 1'b1;
        step(1);
        commit = 1'b0;
        step(300);

        // PWM blanking
        bright = 3'd3;
        step(200);
        bright = 3'd0;
        step(150);
        bright = 3'd7;
        step(40);

        // stalled shifter across a slot start
        wait_phase(SD, 0);
        sh_ready = 1'b0;
        step(20);
        sh_ready = 1'b1;
        step(40);

        // commit and write coincident with a frame boundary
        wait_phase(8 * SD, 8 * SD - 1);
        commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h05;
        step(1);
        commit = 1'b0; wr_en = 1'b0;
        step(300);

        // randomised traffic
        for (int i = 0; i < 2500; i++) begin
            sh_ready = ($urandom_range(0, 9) != 0);
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 5'($urandom_range(0, 31));
            commit   = ($urandom_range(0, 59) == 0);
            blank    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) bright = 3'($urandom_range(0, 7));
            step(1);
        end
        sh_ready = 1'b0; wr_en = 1'b0; commit = 1'b0; blank = 1'b0;

        // reset while a word is pending
        for (int i = 0; i < 40 && !sh_valid; i++) step(1);
        check("pending_before_reset", 16'(sh_valid), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        step(2);
        rst = 1'b0;
        sh_ready = 1'b1;
        bright = 3'd7;
        step(2);
        check("restart_sel", 16'(sh_sel), 16'hFE);
        check("restart_seg", 16'(sh_seg), 16'hC0);
        step(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_sched.md
Name: seg_scan_sched

Overview:
Scan scheduler for the 8-digit 7-segment display driven through the 74HC595 serial shifter. It holds a double-buffered 8-digit frame written by a host. It steps one digit per scan slot, decodes hex+dp to segment patterns, and applies brightness PWM by blanking within each slot. Each {sel,seg} word goes to the HC595 shifter over a valid/ready handshake, so the shifter is sequenced rather than free-running.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot; must be a multiple of 8 and at least 16
DIGITS, 8, number of digits (sel width); fixed at 8 in this revision

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  write one digit into the shadow buffer
wr_addr  in  3  digit index 0..7
wr_data  in  5  {dp, hex[3:0]}
commit  in  1  one-cycle pulse: request shadow->active copy at next frame boundary
bright  in  3  on-time = (bright+1)/8 of each slot
blank  in  1  force blank pattern on every load
sh_valid  out  1  word available to shifter
sh_ready  in  1  shifter can accept a word
sh_sel  out  8  digit select, active-low one-hot
sh_seg  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}
commit_pend  out  1  commit accepted, copy not yet done
frame_tick  out  1  one-cycle pulse at each frame boundary
overrun  out  1  one-cycle pulse when a pending word is replaced unsent

Behaviour:
- Reset (async, rst=1): sh_valid=0, sh_sel=8'hFF, sh_seg=8'hFF, commit_pend=0, frame_tick=0, overrun=0. Slot counter=0, digit index=0. Shadow and active buffers are all 5'h00.
- Slot counter cnt runs 0..SCAN_DIV-1 and wraps. digit index increments at each wrap, 7->0.
- Frame boundary = the cycle where cnt wraps and digit index goes 7->0. Also the first cycle after reset release.
- Load events:
  - Slot start (cnt==0): digit word. sh_sel bit[digit]=0, others 1. sh_seg=decode(active[digit]).
  - Blank point (cnt==(bright+1)*(SCAN_DIV/8)): blank word, sel=8'hFF, seg=8'hFF. No blank point when bright==7.
  - blank=1 sampled at the load event: the digit word is also the blank pattern.
- Latency: a load event in cycle N gives sh_valid=1 with sh_sel/sh_seg updated in cycle N+1.
- Handshake: a transfer occurs on a cycle with sh_valid&&sh_ready. sh_valid drops the next cycle. sh_sel/sh_seg hold their values after transfer until the next load event. Data is stable while sh_valid=1 and no new event occurs.
- Overrun: a load event while sh_valid=1 and the word is unsent replaces the data, keeps sh_valid=1 and pulses overrun for one cycle. If the transfer happens in the same cycle as the event, there is no overrun and the new word is presented next cycle.
- FSM states:
  - IDLE: no pending word. A load event goes to PEND.
  - PEND: sh_valid=1. A transfer goes to IDLE. A load event stays in PEND and raises overrun.
- Double buffer:
  - wr_en writes the shadow only.
  - commit sets commit_pend.
  - At a frame boundary with commit_pend=1: active<=shadow, commit_pend cleared, and the new data is used for digit 0 of that frame.
  - A commit in the same cycle as a boundary is deferred to the next boundary.
  - A wr_en in the boundary cycle is not part of the copy.
  - frame_tick pulses at every boundary, committed or not.
- Decode (active-low):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
  - dp=1 clears bit7.
- bright changes take effect at the next slot start. blank is sampled at each load event.
- Reset mid-transfer: outputs go to reset values immediately, and the word is dropped.

Decomposition:
- Shared package seg_pkg:
  - 16-entry active-low segment table and SEG_BLANK=8'hFF
  - SEL_NONE=8'hFF
  - FSM state enum {IDLE,PEND}
  - DIGIT_W=3
- One natural sub-module: seg_decode (combinational, {dp,hex} -> seg[7:0]), instantiated once on the active-buffer read path.
- The slot counter, FSM and buffers stay in seg_scan_sched.

Test Plan:
1. SCAN_DIV=16, sh_ready=1, release rst -> cycle 1: sh_valid=1, sel=FE, seg=C0. Cycle 17: sel=FD. frame_tick every 128 cycles.
2. wr_en addr3 data 5'h18, then commit mid-frame -> commit_pend=1 until the boundary. Digit 3 shows seg=00 only from the next frame; before that, C0.
3. bright=3 -> per slot: digit word at cnt 0, blank word (FF,FF) at cnt 8. bright=7 -> exactly one transfer per slot.
4. sh_ready=0 for 20 cycles from slot start -> overrun pulse at the next slot start, sh_valid stays 1, sel advances to the next digit. A transfer occurs when ready returns.
5. commit coincident with a frame boundary -> no copy at that boundary, copy at the following one. wr_en in the boundary cycle is not copied.
6. rst asserted while sh_valid=1 -> same cycle: sh_valid=0, sel/seg=FF. After release, scanning restarts at digit 0 showing all C0.
